// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches 16-bit words over a req/ack
// handshake, and feeds the IF/ID buffer with a one-entry skid for decode stalls.
module fetch_stage #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 16'h0000,
  parameter int                  PC_STEP  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hazard,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [3:0]          opcode,
  output logic [3:0]          one,
  output logic [3:0]          two,
  output logic [3:0]          three,
  output logic [PC_WIDTH-1:0] PC,
  output logic                valid
);

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  typedef enum logic [1:0] {
    S_BOOT,
    S_REQ,
    S_PARK,
    S_DROP
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [15:0]         instr_q, instr_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic [15:0]         skid_q, skid_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;

  // While in REQ, pc_q always equals the address being requested.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    valid_d   = valid_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;

    unique case (state_q)
      S_BOOT: state_d = S_REQ;

      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
          end else if (hazard) begin
            skid_d    = imem_data;
            skid_pc_d = req_addr_q;
            pc_d      = pc_q + STEP;
            state_d   = S_PARK;
          end else begin
            instr_d  = imem_data;
            pc_out_d = req_addr_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + STEP;
          end
        end else if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = S_DROP;
        end else if (!hazard) begin
          valid_d = 1'b0;
        end
      end

      S_PARK: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = S_REQ;
        end else if (!hazard) begin
          instr_d  = skid_q;
          pc_out_d = skid_pc_q;
          valid_d  = 1'b1;
          state_d  = S_REQ;
        end
      end

      S_DROP: begin
        // The stale request must still complete before the redirect target is fetched.
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) state_d = S_REQ;
      end

      default: state_d = S_BOOT;
    endcase

    req_addr_d = (state_d == S_REQ) ? pc_d : req_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr = req_addr_q;
  assign opcode    = instr_q[15:12];
  assign one       = instr_q[11:8];
  assign two       = instr_q[7:4];
  assign three     = instr_q[3:0];
  assign PC        = pc_out_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a transaction-level
// model of fetch, stall parking and redirect flushing.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        hazard, redirect;
  logic [15:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_data;
  logic [3:0]  opcode, one, two, three;
  logic [15:0] PC;
  logic        valid;

  logic        hazard2, redirect2;
  logic [15:0] redirect_pc2;
  logic        imem_req2, imem_ack2;
  logic [15:0] imem_addr2, imem_data2;
  logic [3:0]  opcode2, one2, two2, three2;
  logic [15:0] PC2;
  logic        valid2;

  fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000), .PC_STEP(2)) dut (
    .clk(clk), .reset(reset), .hazard(hazard), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .opcode(opcode), .one(one),
    .two(two), .three(three), .PC(PC), .valid(valid)
  );

  fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'hFFFE), .PC_STEP(2)) dut2 (
    .clk(clk), .reset(reset), .hazard(hazard2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack2), .imem_data(imem_data2), .opcode(opcode2), .one(one2),
    .two(two2), .three(three2), .PC(PC2), .valid(valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wait_cnt = 0;
  logic [15:0] mem [256];
  logic [31:0] issued2 [$];

  // Reference model: what has been issued, what is parked, where fetch goes next.
  bit          m_boot, m_park, m_flush;
  logic [15:0] m_next, m_addr, skid_w, skid_pc, o_w, o_pc;
  bit          o_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_park = 0; m_flush = 0;
    m_next = 16'h0000; m_addr = 16'h0000;
    skid_w = 0; skid_pc = 0; o_w = 0; o_pc = 0; o_v = 0;
  endtask

  task automatic model_edge(input bit hz, input bit rd, input logic [15:0] rpc, input bit ack);
    logic [15:0] d;
    if (m_boot) begin
      m_boot = 0;
      m_addr = m_next;
    end else if (m_park) begin
      if (rd) begin
        m_park = 0; o_v = 0; m_next = rpc; m_addr = rpc;
      end else if (!hz) begin
        m_park = 0; o_w = skid_w; o_pc = skid_pc; o_v = 1; m_addr = m_next;
      end
    end else if (m_flush) begin
      if (rd) m_next = rpc;
      if (ack) begin
        m_flush = 0; m_addr = m_next;
      end
    end else if (ack) begin
      d = mem[m_addr[8:1]];
      if (rd) begin
        o_v = 0; m_next = rpc; m_addr = rpc;
      end else if (hz) begin
        skid_w = d; skid_pc = m_addr; m_next = m_addr + 16'd2; m_park = 1;
      end else begin
        o_w = d; o_pc = m_addr; o_v = 1; m_next = m_addr + 16'd2; m_addr = m_next;
      end
    end else if (rd) begin
      o_v = 0; m_next = rpc; m_flush = 1;
    end else if (!hz) begin
      o_v = 0;
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = !m_boot && !m_park;
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_addr);
    chk("fields", {opcode, one, two, three}, o_w);
    chk("PC", PC, o_pc);
    chk("valid", valid, o_v);
    if (valid2) issued2.push_back({opcode2, one2, two2, three2, PC2});
  endtask

  task automatic cycle(input bit hz, input bit rd, input logic [15:0] rpc, input int lat);
    bit req_s, ack_s;
    @(negedge clk);
    hazard = hz; redirect = rd; redirect_pc = rpc;
    req_s = imem_req;
    if (req_s) begin
      imem_ack  = (wait_cnt >= lat);
      imem_data = mem[imem_addr[8:1]];
    end else begin
      imem_ack  = 1'($urandom_range(0, 1));
      imem_data = 16'($urandom);
    end
    ack_s = imem_ack;
    imem_ack2  = imem_req2;
    imem_data2 = {4'h7, imem_addr2[11:0]};
    @(posedge clk);
    if (req_s && ack_s) wait_cnt = 0;
    else if (req_s) wait_cnt++;
    model_edge(hz, rd, rpc, ack_s);
    #1;
    compare();
  endtask

  // Asserts reset between edges so the asynchronous clear is observed at once.
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1; hazard = 0; redirect = 0; imem_ack = 0; imem_ack2 = 0;
    #1;
    chk("rst_req_immediate", imem_req, 1'b0);
    chk("rst_valid_immediate", valid, 1'b0);
    model_reset();
    wait_cnt = 0;
    repeat (n) @(posedge clk);
    #1;
    compare();
    chk("rst_addr", imem_addr, 16'h0000);
    reset = 0;
  endtask

  initial begin
    reset = 1; hazard = 0; redirect = 0; redirect_pc = 0; imem_ack = 0; imem_data = 0;
    hazard2 = 0; redirect2 = 0; redirect_pc2 = 0; imem_ack2 = 0; imem_data2 = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h2345; mem[1] = 16'hABCD; mem[2] = 16'h1111;
    model_reset();

    do_reset(3);

    // Zero-wait memory after reset release
    cycle(0, 0, 16'h0, 0);
    chk("boot_req_rise", imem_req, 1'b1);
    cycle(0, 0, 16'h0, 0);
    chk("zw_instr0", {opcode, one, two, three, PC}, {16'h2345, 16'h0000});
    chk("zw_valid0", valid, 1'b1);
    cycle(0, 0, 16'h0, 0);
    chk("zw_instr1", {opcode, one, two, three, PC}, {16'hABCD, 16'h0002});

    // Hazard for three cycles while the word at 4 returns
    cycle(1, 0, 16'h0, 0);
    chk("park_req_low", imem_req, 1'b0);
    cycle(1, 0, 16'h0, 0);
    cycle(1, 0, 16'h0, 0);
    chk("park_hold", {opcode, one, two, three, PC}, {16'hABCD, 16'h0002});
    cycle(0, 0, 16'h0, 0);
    chk("unpark_instr", {opcode, one, two, three, PC}, {16'h1111, 16'h0004});
    chk("unpark_valid", valid, 1'b1);

    // Redirect to 0x40 while the request to 6 is pending
    cycle(0, 0, 16'h0, 2);
    cycle(0, 1, 16'h0040, 2);
    chk("drop_valid", valid, 1'b0);
    chk("drop_addr_held", imem_addr, 16'h0006);
    cycle(0, 0, 16'h0, 2);
    chk("redirect_addr", imem_addr, 16'h0040);
    cycle(0, 0, 16'h0, 0);
    chk("redirect_issue_pc", PC, 16'h0040);
    chk("redirect_issue_valid", valid, 1'b1);

    // Two-cycle ack latency
    repeat (9) cycle(0, 0, 16'h0, 2);

    // Redirect and hazard together while parked
    cycle(1, 0, 16'h0, 0);
    cycle(1, 1, 16'h0080, 0);
    chk("park_flush_valid", valid, 1'b0);
    chk("park_flush_addr", imem_addr, 16'h0080);
    cycle(0, 0, 16'h0, 0);
    chk("park_flush_issue_pc", PC, 16'h0080);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            {7'b0, 8'($urandom), 1'b0}, $urandom_range(0, 2));
    end

    // Reset pulsed mid-wait, fetch restarts at RESET_PC
    cycle(0, 0, 16'h0, 3);
    cycle(0, 0, 16'h0, 3);
    do_reset(2);
    cycle(0, 0, 16'h0, 0);
    chk("restart_addr", imem_addr, 16'h0000);
    cycle(0, 0, 16'h0, 0);
    chk("restart_pc", PC, 16'h0000);
    chk("restart_instr", {opcode, one, two, three}, 16'h2345);

    // Second instance: RESET_PC=FFFE wraps to 0000
    chk("wrap_count_ok", 32'(issued2.size() >= 2), 32'd1);
    if (issued2.size() >= 2) begin
      chk("wrap_first", issued2[0], {16'h7FFE, 16'hFFFE});
      chk("wrap_second", issued2[1], {16'h7000, 16'h0000});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage. It owns the program counter, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and drives the IF/ID pipeline buffer inputs (opcode/one/two/three/PC).
- It honours the decode-side `hazard` stall and the execute-side branch/jump redirect.
- Sits between instruction memory and the IF/ID buffer.

Parameters:
- PC_WIDTH, 16, program counter and instruction address width.
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, PC increment per fetched instruction (byte-addressed 16-bit words).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- hazard  input  1  stall from hazard unit; holds IF/ID-facing outputs.
- redirect  input  1  branch/jump taken; flush fetch and load redirect_pc.
- redirect_pc  input  PC_WIDTH  redirect target.
- imem_req  output  1  fetch request.
- imem_addr  output  PC_WIDTH  fetch address; stable while imem_req=1 and no ack.
- imem_ack  input  1  memory returns imem_data this cycle.
- imem_data  input  16  instruction word.
- opcode  output  4  imem_data[15:12] of the issued instruction.
- one  output  4  imem_data[11:8].
- two  output  4  imem_data[7:4].
- three  output  4  imem_data[3:0].
- PC  output  PC_WIDTH  address of the issued instruction.
- valid  output  1  outputs hold a real instruction; 0 means bubble.

Behaviour:
- Reset values (async, immediate): opcode/one/two/three=0, PC=0, valid=0, imem_req=0, imem_addr=0, pc=RESET_PC, state=BOOT, skid register cleared.
- A reset asserted mid-transaction drops imem_req combinationally-fast (async clear). Memory must abandon the request.
- Handshake:
  - imem_req held high with imem_addr frozen until a cycle with imem_ack=1.
  - Data is consumed on that rising edge.
  - imem_ack without imem_req is ignored.
  - imem_addr is driven from req_addr, which is loaded from pc when a request is launched.
- Response latency: best case, ack in the same cycle as req. This gives one instruction per cycle, with outputs updating on the edge where ack is sampled.
- Priority when events coincide: reset > redirect > hazard > normal.
- BOOT: imem_req=0 for one cycle after reset release, then go to REQ.
- REQ: imem_req=1.
  - ack & redirect: discard data; pc<=redirect_pc; valid<=0; stay REQ (next request uses redirect_pc).
  - ack & hazard: skid<=imem_data; skid_pc<=req_addr; pc<=pc+PC_STEP; outputs hold; go PARK.
  - ack, no hazard: fields<=slices of imem_data; PC<=req_addr; valid<=1; pc<=pc+PC_STEP; stay REQ with next req_addr=pc+PC_STEP.
  - no ack & redirect: pc<=redirect_pc; valid<=0; go DROP (request remains outstanding).
  - no ack & hazard: outputs hold, including valid.
  - no ack, no hazard: valid<=0 (bubble); fields and PC hold their last values.
- PARK: imem_req=0.
  - redirect: discard skid; pc<=redirect_pc; valid<=0; go REQ.
  - hazard still high: hold.
  - hazard low: outputs<=skid fields; PC<=skid_pc; valid<=1; go REQ.
- DROP: imem_req=1 at the old req_addr.
  - On ack: discard data; go REQ fetching pc.
  - A further redirect in DROP overwrites pc.
  - valid stays 0.
- Hazard with valid=1 never changes outputs. A redirect during hazard forces valid<=0 (flush wins).
- PC arithmetic is modulo 2^PC_WIDTH: 16'hFFFE+2 wraps to 16'h0000.
- At most one outstanding request. Skid depth is 1.

Test Plan:
- Reset then zero-wait memory (ack same cycle, data 16'h2345 at 0, 16'hABCD at 2) -> imem_req rises the cycle after reset release. The following edges give {opcode,one,two,three,PC,valid} = {2,3,4,5,0,1}, then {A,B,C,D,2,1}.
- Memory with 2-cycle ack latency -> imem_addr stable through the wait and valid=0 bubbles between instructions. Each instruction appears for exactly one cycle with valid=1.
- Hazard held 3 cycles while ack returns 16'h1111 at PC 4 -> outputs keep the previous instruction and state=PARK with imem_req=0. One cycle after hazard drops, outputs = {1,1,1,1,4,1}.
- Redirect to 16'h0040 while a request to 6 is pending -> valid=0, DROP. The ack for 6 is discarded, the next imem_addr=16'h0040, and its instruction issues with PC=16'h0040.
- Redirect and hazard asserted together in PARK -> skid discarded, valid=0, the next fetch comes from redirect_pc.
- RESET_PC=16'hFFFE, zero-wait memory -> PCs issued are FFFE, then 0000.
- reset pulsed mid-wait -> imem_req=0 and valid=0 immediately. The fetch restarts at RESET_PC after release.
